// File: rtl/edac_seq_arbiter_if.sv
// rtl/edac_seq_arbiter_if.sv - requester and EDAC_BLOCK side signals of the EDAC sequencer/arbiter
interface edac_seq_arbiter_if #(
  parameter int DW = 32
);
  logic          req0;
  logic          rd0;
  logic [DW-1:0] wdata0;
  logic          done0;
  logic          req1;
  logic          rd1;
  logic [DW-1:0] wdata1;
  logic          done1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          edac_en;
  logic          edac_sel;
  logic          edac_read;
  logic [DW-1:0] edac_din;
  logic [DW-1:0] edac_dout;

  modport slave (
    input  req0, rd0, wdata0, req1, rd1, wdata1, edac_dout,
    output done0, done1, rdata, busy, edac_en, edac_sel, edac_read, edac_din
  );

  modport master (
    output req0, rd0, wdata0, req1, rd1, wdata1, edac_dout,
    input  done0, done1, rdata, busy, edac_en, edac_sel, edac_read, edac_din
  );
endinterface

// File: rtl/edac_seq_arbiter.sv
// rtl/edac_seq_arbiter.sv - round-robin two-port sequencer driving the EDAC_BLOCK issue/select protocol
module edac_seq_arbiter #(
  parameter int DW      = 32,
  parameter int RES_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  edac_seq_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SELECT,
    S_WAIT,
    S_CAPTURE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'((RES_LAT > 0) ? (RES_LAT - 1) : 0);

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic          gnt, gnt_n;
  logic          last_gnt, last_gnt_n;
  logic          rd_l, rd_n;
  logic [DW-1:0] wdata_l, wdata_n;
  logic          win1;

  // Port1 wins when alone, or on a tie when port0 was served last.
  assign win1 = bus.req1 && (!bus.req0 || !last_gnt);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    gnt_n      = gnt;
    last_gnt_n = last_gnt;
    rd_n       = rd_l;
    wdata_n    = wdata_l;
    case (state)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_n   = win1;
          rd_n    = win1 ? bus.rd1 : bus.rd0;
          wdata_n = win1 ? bus.wdata1 : bus.wdata0;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: state_n = S_SELECT;
      S_SELECT: begin
        if (RES_LAT == 0) begin
          state_n = S_CAPTURE;
        end else begin
          state_n = S_WAIT;
          cnt_n   = LAT_M1;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_n = S_CAPTURE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_CAPTURE: begin
        last_gnt_n = gnt;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the EDAC side never sees a req->output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      gnt           <= 1'b0;
      last_gnt      <= 1'b1;
      rd_l          <= 1'b0;
      wdata_l       <= '0;
      bus.done0     <= 1'b0;
      bus.done1     <= 1'b0;
      bus.rdata     <= '0;
      bus.busy      <= 1'b0;
      bus.edac_en   <= 1'b0;
      bus.edac_sel  <= 1'b0;
      bus.edac_read <= 1'b0;
      bus.edac_din  <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      gnt           <= gnt_n;
      last_gnt      <= last_gnt_n;
      rd_l          <= rd_n;
      wdata_l       <= wdata_n;
      bus.done0     <= (state_n == S_CAPTURE) && !gnt_n;
      bus.done1     <= (state_n == S_CAPTURE) && gnt_n;
      bus.busy      <= (state_n != S_IDLE);
      bus.edac_en   <= (state_n == S_ISSUE);
      bus.edac_sel  <= (state_n == S_SELECT);
      bus.edac_read <= (state_n != S_IDLE) ? rd_n : 1'b0;
      bus.edac_din  <= (state_n == S_ISSUE) ? wdata_n : '0;
      if (state == S_CAPTURE) begin
        bus.rdata <= bus.edac_dout;
      end
    end
  end

endmodule

// File: tb/tb_edac_seq_arbiter.sv
// tb/tb_edac_seq_arbiter.sv - self-checking bench with a transaction-level model and a Hamming EDAC stub
module tb_edac_seq_arbiter;
  localparam int DW  = 32;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 clk = ~clk;

  edac_seq_arbiter_if #(.DW(DW)) i0 ();
  edac_seq_arbiter_if #(.DW(DW)) i1 ();

  edac_seq_arbiter #(.DW(DW), .RES_LAT(LAT)) dut0 (.clk(clk), .rst(rst), .bus(i0));
  edac_seq_arbiter #(.DW(DW), .RES_LAT(0))   dut1 (.clk(clk), .rst(rst), .bus(i1));

  // Hamming SEC: positions 1..31 of the codeword, parity bits at powers of two.
  function automatic logic [31:0] enc(input logic [31:0] d);
    logic [31:0] cw;
    logic [4:0]  syn;
    int          j;
    cw = '0;
    j  = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[j];
        j++;
      end
    end
    syn = '0;
    for (int p = 1; p < 32; p++) if (cw[p-1]) syn ^= 5'(p);
    for (int k = 0; k < 5; k++) cw[(1 << k) - 1] = syn[k];
    return cw;
  endfunction

  function automatic logic [31:0] dec(input logic [31:0] c);
    logic [31:0] cw;
    logic [31:0] d;
    logic [4:0]  syn;
    int          j;
    cw  = c;
    syn = '0;
    for (int p = 1; p < 32; p++) if (cw[p-1]) syn ^= 5'(p);
    if (syn != 5'd0) cw[syn - 5'd1] = ~cw[syn - 5'd1];
    d = '0;
    j = 0;
    for (int p = 1; p < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = cw[p-1];
        j++;
      end
    end
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // EDAC_BLOCK stand-ins: operand taken on en, result presented from select onward.
  logic [31:0] s0_din, s1_din;
  logic        s0_rd, s1_rd;
  always @(negedge clk) begin
    if (i0.edac_en) begin s0_din = i0.edac_din; s0_rd = i0.edac_read; end
    if (i0.edac_sel) i0.edac_dout = s0_rd ? dec(s0_din) : enc(s0_din);
    if (i1.edac_en) begin s1_din = i1.edac_din; s1_rd = i1.edac_read; end
    if (i1.edac_sel) i1.edac_dout = s1_rd ? dec(s1_din) : enc(s1_din);
  end

  // Transaction model: an op occupies phases 1..3+LAT after its grant edge.
  logic        m_busy, m_gnt, m_last, m_rd;
  logic [31:0] m_wd, m_rdata;
  int          m_ph;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_ph = 0; m_last = 1'b1; m_rdata = '0; m_gnt = 1'b0; m_rd = 1'b0; m_wd = '0;
    end else begin
      cyc++;
      if (m_busy) begin
        if (m_ph == 3 + LAT) begin
          m_rdata = m_rd ? dec(m_wd) : enc(m_wd);
          m_last  = m_gnt;
          m_busy  = 1'b0;
          m_ph    = 0;
        end else begin
          m_ph++;
        end
      end else if (i0.req0 || i0.req1) begin
        m_gnt  = (i0.req0 && i0.req1) ? !m_last : i0.req1;
        m_rd   = m_gnt ? i0.rd1 : i0.rd0;
        m_wd   = m_gnt ? i0.wdata1 : i0.wdata0;
        m_busy = 1'b1;
        m_ph   = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",      32'(i0.busy),      32'(m_busy));
    chk("edac_en",   32'(i0.edac_en),   32'(m_ph == 1));
    chk("edac_sel",  32'(i0.edac_sel),  32'(m_ph == 2));
    chk("edac_din",  i0.edac_din,       (m_ph == 1) ? m_wd : 32'd0);
    chk("edac_read", 32'(i0.edac_read), 32'(m_busy && m_rd));
    chk("done0",     32'(i0.done0),     32'(m_busy && m_ph == 3 + LAT && !m_gnt));
    chk("done1",     32'(i0.done1),     32'(m_busy && m_ph == 3 + LAT && m_gnt));
    chk("rdata",     i0.rdata,          m_rdata);
  end

  task automatic wait_done(input int port, output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if ((port == 0 && i0.done0) || (port == 1 && i0.done1)) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_done%0d: got no done expected done within 50 cycles", port);
    end
  endtask

  initial begin
    int c0, c1, c2, csel, cdone, nd;
    int order[$];
    int stamp[$];
    i0.req0 = 0; i0.rd0 = 0; i0.wdata0 = '0; i0.req1 = 0; i0.rd1 = 0; i0.wdata1 = '0; i0.edac_dout = '0;
    i1.req0 = 0; i1.rd0 = 0; i1.wdata0 = '0; i1.req1 = 0; i1.rd1 = 0; i1.wdata1 = '0; i1.edac_dout = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(i0.busy), 32'd0);
    chk("reset_rdata", i0.rdata, 32'd0);
    chk("model_enc_F4", enc(32'h000000F4), 32'h00000F22);
    chk("model_dec_flip", dec(32'h00000F22 ^ 32'h00000200), 32'h000000F4);
    chk("model_dec_973C9", dec(32'h000973C9), 32'h00004F38);
    rst = 1'b0;

    // Both requesting from reset: port0 first, then strict alternation.
    @(negedge clk);
    i0.req0 = 1; i0.rd0 = 1; i0.wdata0 = 32'h000973C9;
    i0.req1 = 1; i0.rd1 = 0; i0.wdata1 = 32'h000000F4;
    for (int k = 0; k < 60 && order.size() < 4; k++) begin
      @(negedge clk);
      if (i0.done0) begin order.push_back(0); stamp.push_back(cyc); end
      if (i0.done1) begin order.push_back(1); stamp.push_back(cyc); end
    end
    i0.req0 = 0; i0.req1 = 0;
    chk("rr_count", 32'(order.size()), 32'd4);
    if (order.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("rr_order", 32'(order[k]), 32'(k % 2));
      for (int k = 1; k < 4; k++) chk("rr_period", 32'(stamp[k] - stamp[k-1]), 32'd5);
    end
    repeat (2) @(negedge clk);

    // Single read on port0 with literal protocol checks.
    i0.req0 = 1; i0.rd0 = 1; i0.wdata0 = 32'h000973C9;
    c0 = cyc;
    @(negedge clk);
    chk("issue_en", 32'(i0.edac_en), 32'd1);
    chk("issue_sel", 32'(i0.edac_sel), 32'd0);
    chk("issue_read", 32'(i0.edac_read), 32'd1);
    chk("issue_din", i0.edac_din, 32'h000973C9);
    i0.wdata0 = 32'hFFFFFFFF; i0.rd0 = 0;
    @(negedge clk);
    chk("select_en", 32'(i0.edac_en), 32'd0);
    chk("select_sel", 32'(i0.edac_sel), 32'd1);
    chk("select_din", i0.edac_din, 32'd0);
    wait_done(0, c1);
    i0.req0 = 0;
    chk("read_latency", 32'(c1 - c0), 32'd4);
    @(negedge clk);
    chk("read_rdata", i0.rdata, 32'h00004F38);

    // Reset asserted in WAIT: everything clears asynchronously.
    i0.req0 = 1; i0.rd0 = 0; i0.wdata0 = 32'h000000F4;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(i0.busy), 32'd0);
    chk("arst_en_sel_read", {29'd0, i0.edac_en, i0.edac_sel, i0.edac_read}, 32'd0);
    chk("arst_din", i0.edac_din, 32'd0);
    chk("arst_done", {30'd0, i0.done0, i0.done1}, 32'd0);
    chk("arst_rdata", i0.rdata, 32'd0);
    i0.req0 = 0;
    @(negedge clk);
    rst = 1'b0;

    // Single write on port1.
    @(negedge clk);
    i0.req1 = 1; i0.rd1 = 0; i0.wdata1 = 32'h000000F4;
    c0 = cyc;
    wait_done(1, c1);
    i0.req1 = 0;
    chk("write_latency", 32'(c1 - c0), 32'd4);
    @(negedge clk);
    chk("write_rdata", i0.rdata, 32'h00000F22);

    // Back-to-back reads, second operand carries a single-bit error.
    i0.req0 = 1; i0.rd0 = 1; i0.wdata0 = 32'h000973C9;
    wait_done(0, c1);
    i0.wdata0 = 32'h000973C1;
    wait_done(0, c2);
    i0.req0 = 0;
    chk("b2b_period", 32'(c2 - c1), 32'd5);
    @(negedge clk);
    chk("b2b_corrected", i0.rdata, 32'h00004F38);

    // req0 dropped during SELECT: op still completes with exactly one done.
    i0.req0 = 1; i0.rd0 = 0; i0.wdata0 = 32'h00001234;
    repeat (2) @(negedge clk);
    i0.req0 = 0;
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (i0.done0) nd++;
    end
    chk("drop_done_count", 32'(nd), 32'd1);

    // Zero-latency build: CAPTURE directly follows SELECT.
    i1.req1 = 1; i1.rd1 = 0; i1.wdata1 = 32'h000000F4;
    csel = -1; cdone = -1; nd = 0;
    for (int k = 0; k < 20 && cdone < 0; k++) begin
      @(negedge clk);
      if (i1.edac_sel) csel = cyc;
      if (i1.done1) begin cdone = cyc; nd++; end
      if (i1.done0) nd = nd + 100;
    end
    i1.req1 = 0;
    chk("lat0_sel_to_done", 32'(cdone - csel), 32'd1);
    chk("lat0_done_count", 32'(nd), 32'd1);
    @(negedge clk);
    chk("lat0_rdata", i1.rdata, 32'h00000F22);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
